// File: rtl/vr_handshake_monitor.sv
// Passive valid/ready protocol monitor: per-channel stall timeout, early valid drop and
// payload-instability detection, with sticky flags, a saturating event count and an irq pulse.
module vr_handshake_monitor #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 2,
    parameter int CNT_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        valid_i,
    input  logic [NUM_CH-1:0]        ready_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic [NUM_CH-1:0]        err_timeout_o,
    output logic [NUM_CH-1:0]        err_drop_o,
    output logic [NUM_CH-1:0]        err_unstable_o,
    output logic                     err_any_o,
    output logic [CNT_W-1:0]         err_count_o,
    output logic                     irq_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam int EV_W   = $clog2(3 * NUM_CH + 1);
    localparam int SUM_W  = ((CNT_W > EV_W) ? CNT_W : EV_W) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_TIMEOUT
    } state_e;

    logic [NUM_CH-1:0] ev_timeout;
    logic [NUM_CH-1:0] ev_drop;
    logic [NUM_CH-1:0] ev_unstable;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e              state_q, state_d;
        logic [WAIT_W-1:0]   wait_q, wait_d;
        logic [DATA_W-1:0]   cap_q, cap_d;
        logic                unst_q, unst_d;
        logic [DATA_W-1:0]   payload;
        logic                to_ev, drop_ev, un_ev;

        assign payload = data_i[g*DATA_W +: DATA_W];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= S_IDLE;
                wait_q  <= '0;
                cap_q   <= '0;
                unst_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                wait_q  <= wait_d;
                cap_q   <= cap_d;
                unst_q  <= unst_d;
            end
        end

        // unst_q limits the instability report to one per stall; payload is only judged while valid
        always_comb begin
            state_d = state_q;
            wait_d  = wait_q;
            cap_d   = cap_q;
            unst_d  = unst_q;
            to_ev   = 1'b0;
            drop_ev = 1'b0;
            un_ev   = 1'b0;
            if (!enable_i) begin
                state_d = S_IDLE;
                wait_d  = '0;
                unst_d  = 1'b0;
            end else begin
                if (state_q != S_IDLE && valid_i[g] && payload != cap_q && !unst_q) begin
                    un_ev  = 1'b1;
                    unst_d = 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (valid_i[g] && !ready_i[g]) begin
                            state_d = S_STALL;
                            wait_d  = WAIT_W'(1);
                            cap_d   = payload;
                            unst_d  = 1'b0;
                        end
                    end
                    S_STALL: begin
                        if (!valid_i[g]) begin
                            drop_ev = 1'b1;
                            state_d = S_IDLE;
                            wait_d  = '0;
                        end else if (ready_i[g]) begin
                            state_d = S_IDLE;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                            if (wait_d == WAIT_LIMIT) begin
                                to_ev   = 1'b1;
                                state_d = S_TIMEOUT;
                            end
                        end
                    end
                    S_TIMEOUT: begin
                        if (!valid_i[g] || ready_i[g]) begin
                            state_d = S_IDLE;
                            wait_d  = '0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        wait_d  = '0;
                    end
                endcase
            end
        end

        assign ev_timeout[g]  = to_ev;
        assign ev_drop[g]     = drop_ev;
        assign ev_unstable[g] = un_ev;
    end

    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] drop_q, drop_d;
    logic [NUM_CH-1:0] un_q, un_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_q, irq_d;
    logic [EV_W-1:0]   ev_total;
    logic [SUM_W-1:0]  base, sum;

    always_comb begin
        ev_total = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ev_total = ev_total + EV_W'(ev_timeout[i]) + EV_W'(ev_drop[i]) + EV_W'(ev_unstable[i]);
        end
    end

    // A clear in the same cycle as new events leaves exactly this cycle's events behind
    always_comb begin
        base    = clear_i ? '0 : SUM_W'(count_q);
        sum     = base + SUM_W'(ev_total);
        count_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        to_d    = (clear_i ? '0 : to_q) | ev_timeout;
        drop_d  = (clear_i ? '0 : drop_q) | ev_drop;
        un_d    = (clear_i ? '0 : un_q) | ev_unstable;
        irq_d   = (ev_total != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_q    <= '0;
            drop_q  <= '0;
            un_q    <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            to_q    <= to_d;
            drop_q  <= drop_d;
            un_q    <= un_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    assign err_timeout_o  = to_q;
    assign err_drop_o     = drop_q;
    assign err_unstable_o = un_q;
    assign err_any_o      = |{to_q, drop_q, un_q};
    assign err_count_o    = count_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_vr_handshake_monitor.sv
// Self-checking bench for vr_handshake_monitor: directed protocol scenarios then random traffic,
// compared against a stall-length based reference model; a CNT_W=2 copy exercises count saturation.
module tb_vr_handshake_monitor;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     clear;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        ready;
    logic [NUM_CH*DATA_W-1:0] data;

    logic [NUM_CH-1:0] toA, dropA, unA, toB, dropB, unB;
    logic              anyA, anyB, irqA, irqB;
    logic [7:0]        cntA;
    logic [1:0]        cntB;

    int checks   = 0;
    int failures = 0;

    int          stallLen [NUM_CH];
    logic [31:0] capData  [NUM_CH];
    bit          unstSeen [NUM_CH];
    logic [NUM_CH-1:0] mTo, mDrop, mUn;
    int          mCntA, mCntB;
    bit          mIrq;

    always #5 clk = ~clk;

    vr_handshake_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(8)) dutA (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .valid_i(valid), .ready_i(ready), .data_i(data),
        .err_timeout_o(toA), .err_drop_o(dropA), .err_unstable_o(unA),
        .err_any_o(anyA), .err_count_o(cntA), .irq_o(irqA)
    );

    vr_handshake_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(2)) dutB (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .valid_i(valid), .ready_i(ready), .data_i(data),
        .err_timeout_o(toB), .err_drop_o(dropB), .err_unstable_o(unB),
        .err_any_o(anyB), .err_count_o(cntB), .irq_o(irqB)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("err_timeout", 32'(toA), 32'(mTo));
        checkValue("err_drop", 32'(dropA), 32'(mDrop));
        checkValue("err_unstable", 32'(unA), 32'(mUn));
        checkValue("err_any", 32'(anyA), 32'(|{mTo, mDrop, mUn}));
        checkValue("err_count", 32'(cntA), 32'(mCntA));
        checkValue("irq", 32'(irqA), 32'(mIrq));
        checkValue("b_err_flags", 32'({toB, dropB, unB}), 32'({mTo, mDrop, mUn}));
        checkValue("b_err_count", 32'(cntB), 32'(mCntB));
        checkValue("b_irq", 32'(irqB), 32'(mIrq));
    endtask

    function automatic logic [31:0] payloadOf(input int ch);
        return data[ch*DATA_W +: DATA_W];
    endfunction

    task automatic setData(input int ch, input logic [31:0] val);
        data[ch*DATA_W +: DATA_W] = val;
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            stallLen[ch] = 0;
            capData[ch]  = '0;
            unstSeen[ch] = 1'b0;
        end
        mTo = '0; mDrop = '0; mUn = '0;
        mCntA = 0; mCntB = 0; mIrq = 1'b0;
    endtask

    // stallLen counts stalled samples of the current stall without limit; a stall that has
    // already run past MAX_WAIT has timed out, so a later drop is not reported
    task automatic modelStep();
        int ev = 0;
        logic [NUM_CH-1:0] nTo = '0, nDrop = '0, nUn = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!enable) begin
                stallLen[ch] = 0;
            end else if (stallLen[ch] > 0) begin
                if (valid[ch] && payloadOf(ch) != capData[ch] && !unstSeen[ch]) begin
                    nUn[ch] = 1'b1; unstSeen[ch] = 1'b1; ev++;
                end
                if (!valid[ch]) begin
                    if (stallLen[ch] <= MAX_WAIT) begin nDrop[ch] = 1'b1; ev++; end
                    stallLen[ch] = 0;
                end else if (ready[ch]) begin
                    stallLen[ch] = 0;
                end else begin
                    stallLen[ch]++;
                    if (stallLen[ch] == MAX_WAIT + 1) begin nTo[ch] = 1'b1; ev++; end
                end
            end else if (valid[ch] && !ready[ch]) begin
                stallLen[ch] = 1;
                capData[ch]  = payloadOf(ch);
                unstSeen[ch] = 1'b0;
            end
        end
        mTo   = (clear ? '0 : mTo) | nTo;
        mDrop = (clear ? '0 : mDrop) | nDrop;
        mUn   = (clear ? '0 : mUn) | nUn;
        mCntA = (clear ? 0 : mCntA) + ev;
        if (mCntA > 255) mCntA = 255;
        mCntB = (clear ? 0 : mCntB) + ev;
        if (mCntB > 3) mCntB = 3;
        mIrq = (ev > 0);
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                                 input logic en, input logic clr);
        valid = v; ready = r; enable = en; clear = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [NUM_CH-1:0] rv, rr;
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        valid = '0; ready = '0; data = '0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] scenario 1: ch0 timeout");
        repeat (3) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        checkValue("t1_timeout0", 32'(toA[0]), 32'd1);
        checkValue("t1_count", 32'(cntA), 32'd1);
        checkValue("t1_irq_high", 32'(irqA), 32'd1);
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
        checkValue("t1_irq_low", 32'(irqA), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] scenario 2: stall of exactly MAX_WAIT");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        repeat (2) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
        checkValue("t2_count", 32'(cntA), 32'd0);
        checkValue("t2_any", 32'(anyA), 32'd0);

        $display("[TB] scenario 3: ch1 drop then long stall");
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkValue("t3_drop1", 32'(dropA[1]), 32'd1);
        checkValue("t3_count_drop", 32'(cntA), 32'd1);
        repeat (5) applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
        checkValue("t3_count_long", 32'(cntA), 32'd2);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] scenario 4: ch2 unstable with timeout");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        setData(2, 32'hA5A5_A5A5);
        repeat (2) applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0);
        setData(2, 32'h0000_0000);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0);
        checkValue("t4_flags2", 32'({unA[2], toA[2]}), 32'b11);
        checkValue("t4_count", 32'(cntA), 32'd2);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] scenario 5: simultaneous timeouts with clear, saturation");
        repeat (2) applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b1);
        checkValue("t5_flags", 32'(toA), 32'b1001);
        checkValue("t5_count", 32'(cntA), 32'd2);
        checkValue("t5_count_b", 32'(cntB), 32'd2);
        applyStimulus(4'b1001, 4'b1001, 1'b1, 1'b0);
        repeat (3) applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b0);
        checkValue("t5_count_more", 32'(cntA), 32'd4);
        checkValue("t5_count_b_sat", 32'(cntB), 32'd3);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] scenario 6: enable drop restarts a stall");
        repeat (2) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
        repeat (2) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        checkValue("t6_no_timeout", 32'(toA[0]), 32'd0);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        checkValue("t6_timeout", 32'(toA[0]), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] scenario 7: reset mid-stall");
        repeat (2) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
        checkValue("t7_count", 32'(cntA), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 9) == 0) setData(ch, 32'($urandom_range(0, 3)));
                rv[ch] = ($urandom_range(0, 4) != 0);
                rr[ch] = ($urandom_range(0, 2) == 0);
            end
            applyStimulus(rv, rr, $urandom_range(0, 29) != 0, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
